// File: rtl/decode_writeback_seq.sv
// decode_writeback_seq: SEQ Y86-64 decode/register-file/writeback stage; WB_BYPASS_EN forwards same-cycle writes to reads.
module decode_writeback_seq #(
  parameter logic [63:0] RSP_INIT = 64'd0,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       in_code,
  input  logic [3:0]       in_fun,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic             cnd,
  input  logic [63:0]      val_e,
  input  logic [63:0]      val_m,
  input  logic             wb_en,
  input  logic             flag_halt,
  input  logic             bad_mem,
  input  logic             in_error,
  output logic [3:0]       src_a,
  output logic [3:0]       src_b,
  output logic [3:0]       dst_e,
  output logic [3:0]       dst_m,
  output logic [63:0]      val_a,
  output logic [63:0]      val_b,
  output logic             halted,
  output logic [CNT_W-1:0] wb_count,
  input  logic [3:0]       dbg_addr,
  output logic [63:0]      dbg_data
);
  logic [63:0] regs [0:14];
  logic write_ok, we_e, we_m, unused;
  assign unused = ^in_fun;
  always_comb begin
    src_a = (in_code inside {4'h2, 4'h4, 4'h6, 4'hA}) ? ra : (in_code inside {4'h9, 4'hB}) ? 4'd4 : 4'hF;
    src_b = (in_code inside {4'h4, 4'h5, 4'h6}) ? rb : (in_code inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : 4'hF;
    dst_e = ((in_code == 4'h2 && cnd) || in_code inside {4'h3, 4'h6}) ? rb :
            (in_code inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'd4 : 4'hF;
    dst_m = (in_code inside {4'h5, 4'hB}) ? ra : 4'hF;
  end
  assign write_ok = !halted && !bad_mem && !in_error && !flag_halt;
  assign we_e = wb_en && write_ok && dst_e != 4'hF;
  assign we_m = wb_en && write_ok && dst_m != 4'hF;
  function automatic logic [63:0] rd(input logic [3:0] addr);
`ifdef WB_BYPASS_EN
    rd = (addr == 4'hF) ? 64'd0 : (we_m && addr == dst_m) ? val_m : (we_e && addr == dst_e) ? val_e : regs[addr];
`else
    rd = (addr == 4'hF) ? 64'd0 : regs[addr];
`endif
  endfunction
  assign val_a = rd(src_a);
  assign val_b = rd(src_b);
  assign dbg_data = rd(dbg_addr);
  // M port is assigned last so it wins when dst_e == dst_m
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
      halted <= 1'b0;
      wb_count <= '0;
    end else begin
      if (we_e) regs[dst_e] <= val_e;
      if (we_m) regs[dst_m] <= val_m;
      if (we_e || we_m) wb_count <= wb_count + 1'b1;
      if (wb_en && (flag_halt || bad_mem || in_error)) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_decode_writeback_seq.sv
// tb_decode_writeback_seq: directed checks of decode, writeback, halt latching and optional bypass.
module tb_decode_writeback_seq;
  localparam logic [63:0] RSP = 64'h100;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clock = 0, reset_n = 0;
  logic [3:0] in_code, in_fun, ra, rb, dbg_addr;
  logic cnd, wb_en, flag_halt, bad_mem, in_error;
  logic [63:0] val_e, val_m;
  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic [63:0] val_a, val_b, dbg_data;
  logic halted;
  logic [15:0] wb_count;
  int tests = 0, fails = 0;

  decode_writeback_seq #(.RSP_INIT(RSP), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .in_code(in_code), .in_fun(in_fun), .ra(ra), .rb(rb),
    .cnd(cnd), .val_e(val_e), .val_m(val_m), .wb_en(wb_en), .flag_halt(flag_halt),
    .bad_mem(bad_mem), .in_error(in_error), .src_a(src_a), .src_b(src_b), .dst_e(dst_e),
    .dst_m(dst_m), .val_a(val_a), .val_b(val_b), .halted(halted), .wb_count(wb_count),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_code = 4'h1; in_fun = 0; ra = 4'hF; rb = 4'hF; cnd = 0; wb_en = 0;
    flag_halt = 0; bad_mem = 0; in_error = 0; val_e = 0; val_m = 0; dbg_addr = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    #2;
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk($sformatf("reset_reg%0d", i), dbg_data, (i == 4) ? RSP : 64'd0);
    end
    chk("reset_halted", {63'd0, halted}, 64'd0);
    chk("reset_wb_count", {48'd0, wb_count}, 64'd0);
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_irmov_rrmov();
    idle();
    in_code = 4'h3; rb = 4'd2; val_e = 64'h1234; wb_en = 1; dbg_addr = 4'd2;
    #1;
    chk("irmov_dst_e", {60'd0, dst_e}, 64'd2);
    chk("irmov_src_a", {60'd0, src_a}, 64'hF);
    chk("irmov_src_b", {60'd0, src_b}, 64'hF);
    chk("irmov_pre_edge_dbg", dbg_data, BYP ? 64'h1234 : 64'd0);
    tick();
    idle();
    in_code = 4'h2; ra = 4'd2; rb = 4'd5; cnd = 1;
    #1;
    chk("rrmov_src_a", {60'd0, src_a}, 64'd2);
    chk("rrmov_val_a", val_a, 64'h1234);
    chk("rrmov_dst_e", {60'd0, dst_e}, 64'd5);
    chk("irmov_wb_count", {48'd0, wb_count}, 64'd1);
  endtask

  task automatic test_pop_m_wins();
    idle();
    in_code = 4'hB; ra = 4'd4; val_e = 64'h108; val_m = 64'hAA; wb_en = 1; dbg_addr = 4'd4;
    #1;
    chk("pop_dst_e", {60'd0, dst_e}, 64'd4);
    chk("pop_dst_m", {60'd0, dst_m}, 64'd4);
    chk("pop_src_a", {60'd0, src_a}, 64'd4);
    chk("pop_val_b", val_b, BYP ? 64'hAA : RSP);
    tick();
    wb_en = 0;
    #1;
    chk("pop_reg4", dbg_data, 64'hAA);
    chk("pop_wb_count", {48'd0, wb_count}, 64'd2);
  endtask

  task automatic test_cmov_not_taken();
    idle();
    in_code = 4'h2; cnd = 0; ra = 4'd1; rb = 4'd3; val_e = 64'd5; wb_en = 1; dbg_addr = 4'd3;
    #1;
    chk("cmov_dst_e", {60'd0, dst_e}, 64'hF);
    chk("cmov_src_a", {60'd0, src_a}, 64'd1);
    tick();
    wb_en = 0;
    #1;
    chk("cmov_reg3", dbg_data, 64'd0);
    chk("cmov_wb_count", {48'd0, wb_count}, 64'd2);
  endtask

  task automatic test_opq_bypass();
    idle();
    in_code = 4'h6; ra = 4'd2; rb = 4'd6; val_e = 64'd7; wb_en = 1; dbg_addr = 4'd6;
    #1;
    chk("opq_pre_dbg", dbg_data, BYP ? 64'd7 : 64'd0);
    chk("opq_pre_val_b", val_b, BYP ? 64'd7 : 64'd0);
    chk("opq_val_a", val_a, 64'h1234);
    tick();
    wb_en = 0;
    #1;
    chk("opq_post_dbg", dbg_data, 64'd7);
    chk("opq_wb_count", {48'd0, wb_count}, 64'd3);
  endtask

  task automatic test_decode_misc();
    idle();
    in_code = 4'h8; ra = 4'd1; rb = 4'd2;
    #1;
    chk("call_src_a", {60'd0, src_a}, 64'hF);
    chk("call_src_b", {60'd0, src_b}, 64'd4);
    chk("call_dst_e", {60'd0, dst_e}, 64'd4);
    in_code = 4'h5; ra = 4'd7; rb = 4'd3;
    #1;
    chk("mrmov_src_b", {60'd0, src_b}, 64'd3);
    chk("mrmov_dst_m", {60'd0, dst_m}, 64'd7);
    chk("mrmov_dst_e", {60'd0, dst_e}, 64'hF);
    in_code = 4'hC; ra = 4'd1; rb = 4'd2; cnd = 1;
    #1;
    chk("bad_code_ids", {48'd0, src_a, src_b, dst_e, dst_m}, 64'hFFFF);
    in_code = 4'h3; rb = 4'd8; val_e = 64'h99; bad_mem = 1; wb_en = 0;
    tick();
    chk("badmem_noen_halted", {63'd0, halted}, 64'd0);
    chk("badmem_noen_count", {48'd0, wb_count}, 64'd3);
  endtask

  task automatic test_halt();
    idle();
    in_code = 4'h3; rb = 4'd1; val_e = 64'h55; wb_en = 1; flag_halt = 1; dbg_addr = 4'd1;
    tick();
    flag_halt = 0;
    #1;
    chk("halt_set", {63'd0, halted}, 64'd1);
    chk("halt_same_cycle_reg1", dbg_data, 64'd0);
    val_e = 64'h77;
    tick();
    chk("halt_after_reg1", dbg_data, 64'd0);
    chk("halt_wb_count", {48'd0, wb_count}, 64'd3);
    chk("halt_sticky", {63'd0, halted}, 64'd1);
    reset_n = 0;
    #1;
    chk("async_reset_halted", {63'd0, halted}, 64'd0);
    chk("async_reset_count", {48'd0, wb_count}, 64'd0);
    dbg_addr = 4'd6;
    #1;
    chk("async_reset_reg6", dbg_data, 64'd0);
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    test_reset();
    test_irmov_rrmov();
    test_pop_m_wins();
    test_cmov_not_taken();
    test_opq_bypass();
    test_decode_misc();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_writeback_seq.md
Name: decode_writeback_seq

Overview:
- Register-file stage of the SEQ Y86-64 processor, directly downstream of the fetch stage.
- Consumes in_code, ra and rb from fetch, and reads the 15 program registers combinationally to produce val_a and val_b.
- Writes val_e and val_m back on the rising clock edge.
- Latches halt and error status so that no architectural state changes after a halt, bad_mem or in_error.

Parameters:
- RSP_INIT, 64'd0, reset value of register 4 (%rsp); all other registers reset to 0.
- CNT_W, 16, width of the retired-writeback counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_code  input  4  instruction code from fetch.
- in_fun  input  4  function code from fetch; passed through, unused internally.
- ra  input  4  rA field from fetch.
- rb  input  4  rB field from fetch.
- cnd  input  1  condition flag from execute; qualifies cmovXX writeback.
- val_e  input  64  execute result.
- val_m  input  64  memory read result.
- wb_en  input  1  high when the current instruction completes this cycle.
- flag_halt  input  1  halt indication from fetch.
- bad_mem  input  1  fetch address error.
- in_error  input  1  illegal instruction from fetch.
- src_a  output  4  decoded A-port register ID.
- src_b  output  4  decoded B-port register ID.
- dst_e  output  4  decoded E-port destination ID.
- dst_m  output  4  decoded M-port destination ID.
- val_a  output  64  contents of src_a, or 0 if src_a==15.
- val_b  output  64  contents of src_b, or 0 if src_b==15.
- halted  output  1  sticky stop status.
- wb_count  output  CNT_W  count of cycles in which at least one register was written.
- dbg_addr  input  4  debug read address.
- dbg_data  output  64  contents of dbg_addr, or 0 if dbg_addr==15.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n low, asynchronous):
  - registers 0-14 go to 0, except reg 4 = RSP_INIT;
  - halted=0, wb_count=0.
  - Reset mid-operation discards any pending write in that cycle.
- ID decode (combinational, 15 = none; in_code values: 0 halt, 1 nop, 2 rrmov/cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OPq, 7 jXX, 8 call, 9 ret, A push, B pop):
  - src_a = ra for codes 2,4,6,A; 4 for codes 9,B; else 15.
  - src_b = rb for codes 4,5,6; 4 for codes 8,9,A,B; else 15.
  - dst_e = rb for code 2 when cnd=1, and for codes 3,6; 4 for codes 8,9,A,B; else 15. Code 2 with cnd=0 gives dst_e=15.
  - dst_m = ra for codes 5,B; else 15.
  - Any code >11 gives all four IDs = 15.
- Read: val_a, val_b and dbg_data are purely combinational from register state; zero latency.
- Write, at posedge clock when wb_en=1 and write_ok=1, where write_ok = !halted && !bad_mem && !in_error && !flag_halt:
  - reg[dst_e] <= val_e if dst_e != 15;
  - reg[dst_m] <= val_m if dst_m != 15.
  - If dst_e == dst_m (e.g. popq %rsp), the M port wins and val_m is stored.
  - Writes to ID 15 are discarded; there is no physical register 15.
- wb_count: increments by 1 on each clock edge where at least one write occurs; wraps from all-ones to 0.
- halted:
  - set at posedge when wb_en=1 and any of flag_halt, bad_mem or in_error is 1;
  - sticky until reset;
  - while halted, no writes occur and wb_count holds.
  - Writes from the same cycle that sets halted are suppressed.
- Same-cycle read/write: reads return pre-edge contents (no bypass) unless WB_BYPASS_EN is defined.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: when a write to register X is enabled in the current cycle, val_a, val_b and dbg_data addressing X return the incoming write data combinationally, with M taking priority over E.
- Undefined: they return the stored value and the new value is visible the cycle after the edge.

Test Plan:
1. Reset with RSP_INIT=64'h100 -> reg4 reads 0x100, all others 0, halted=0, wb_count=0.
2. irmovq in_code=3, rb=2, val_e=0x1234, wb_en=1 for one edge; then rrmovq ra=2 -> dst_e=2; next cycle src_a=2 and val_a=0x1234; wb_count=1.
3. popq in_code=B, ra=4, val_e=0x108, val_m=0xAA, wb_en=1 -> dst_e=dst_m=4; after the edge reg4=0xAA (M wins).
4. cmov in_code=2, cnd=0, rb=3, val_e=5 -> dst_e=15; reg3 unchanged; wb_count unchanged.
5. flag_halt=1 with wb_en=1 -> halted=1 after the edge; a following irmovq to reg1 leaves reg1=0; wb_count frozen; asserting reset_n low clears halted without waiting for a clock edge.
6. With WB_BYPASS_EN defined: OPq rb=6, val_e=7, wb_en=1, dbg_addr=6 -> dbg_data=7 before the edge. Without the macro: dbg_data=0 before the edge and 7 after it.
